// File: rtl/color_pkg.sv
// Colour codes shared by the frame judge and the display overlay, plus the
// judge's debounce state encoding.
package color_pkg;

  typedef enum logic [1:0] {
    COLOR_NONE  = 2'b00,
    COLOR_RED   = 2'b01,
    COLOR_GREEN = 2'b10,
    COLOR_BLUE  = 2'b11
  } color_t;

  typedef enum logic [1:0] {
    S_WHITE  = 2'b00,
    S_SEARCH = 2'b01,
    S_LOCKED = 2'b10
  } judge_state_t;

endpackage

// File: rtl/roi_color_counter.sv
// Per-frame saturating R/G/B/W pixel counters with a snapshot taken on
// frame_end; the live counters restart from zero the cycle after.
module roi_color_counter #(
  parameter int CNT_W = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pixel_valid,
  input  logic             in_roi,
  input  logic             is_red,
  input  logic             is_green,
  input  logic             is_blue,
  input  logic             is_white,
  input  logic             frame_end,
  output logic [CNT_W-1:0] snap_r,
  output logic [CNT_W-1:0] snap_g,
  output logic [CNT_W-1:0] snap_b,
  output logic [CNT_W-1:0] snap_w,
  output logic             snap_valid
);

  logic [CNT_W-1:0] cnt  [4];
  logic [CNT_W-1:0] nxt  [4];
  logic [CNT_W-1:0] snap [4];
  logic [3:0]       hit;

  // nxt already includes the pixel of the current cycle, so the frame_end
  // pixel lands in the snapshot of the frame it closes.
  always_comb begin
    hit = {is_white, is_blue, is_green, is_red} & {4{pixel_valid && in_roi}};
    for (int k = 0; k < 4; k++) begin
      nxt[k] = (hit[k] && (cnt[k] != '1)) ? cnt[k] + CNT_W'(1) : cnt[k];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      snap_valid <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        cnt[k]  <= '0;
        snap[k] <= '0;
      end
    end else begin
      snap_valid <= frame_end;
      for (int k = 0; k < 4; k++) begin
        if (frame_end) begin
          snap[k] <= nxt[k];
          cnt[k]  <= '0;
        end else begin
          cnt[k]  <= nxt[k];
        end
      end
    end
  end

  assign snap_r = snap[0];
  assign snap_g = snap[1];
  assign snap_b = snap[2];
  assign snap_w = snap[3];

endmodule

// File: rtl/dice_color_judge.sv
// Frame-level dominant colour judge with debounce FSM. Define
// DICE_JUDGE_COUNT_OUT_EN to expose the per-frame snapshot counts.
module dice_color_judge
  import color_pkg::*;
#(
  parameter int               CNT_W         = 14,
  parameter logic [CNT_W-1:0] MIN_PIXELS    = 14'd800,
  parameter logic [CNT_W-1:0] WHITE_PIXELS  = 14'd10000,
  parameter int               STABLE_FRAMES = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pixel_valid,
  input  logic             in_roi,
  input  logic             is_red,
  input  logic             is_green,
  input  logic             is_blue,
  input  logic             is_white,
  input  logic             frame_end,
  output logic [1:0]       dominant_color,
  output logic             white_detected,
  output logic [1:0]       state_dbg,
  // result_valid is a one-cycle strobe with no back-pressure: the consumer
  // must sample dominant_color in the same cycle it is high.
  output logic             result_valid
`ifdef DICE_JUDGE_COUNT_OUT_EN
  ,
  output logic [CNT_W-1:0] dbg_cnt_r,
  output logic [CNT_W-1:0] dbg_cnt_g,
  output logic [CNT_W-1:0] dbg_cnt_b,
  output logic [CNT_W-1:0] dbg_cnt_w
`endif
);

  localparam int          SW   = $clog2(STABLE_FRAMES + 1);
  localparam logic [SW-1:0] SMAX = SW'(STABLE_FRAMES);

  logic [CNT_W-1:0] snap_r, snap_g, snap_b, snap_w;
  logic             snap_valid;

  roi_color_counter #(.CNT_W(CNT_W)) u_counter (
    .clk        (clk),
    .reset      (reset),
    .pixel_valid(pixel_valid),
    .in_roi     (in_roi),
    .is_red     (is_red),
    .is_green   (is_green),
    .is_blue    (is_blue),
    .is_white   (is_white),
    .frame_end  (frame_end),
    .snap_r     (snap_r),
    .snap_g     (snap_g),
    .snap_b     (snap_b),
    .snap_w     (snap_w),
    .snap_valid (snap_valid)
  );

  // Frame classification; >= comparisons give the R > G > B tie order.
  logic [CNT_W-1:0] best;
  color_t           best_c, frame_color;
  logic             cls_valid, cls_white;
  color_t           cls_color;

  always_comb begin
    if (snap_r >= snap_g && snap_r >= snap_b) begin
      best = snap_r; best_c = COLOR_RED;
    end else if (snap_g >= snap_b) begin
      best = snap_g; best_c = COLOR_GREEN;
    end else begin
      best = snap_b; best_c = COLOR_BLUE;
    end
    frame_color = (best >= MIN_PIXELS) ? best_c : COLOR_NONE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cls_valid <= 1'b0;
      cls_white <= 1'b0;
      cls_color <= COLOR_NONE;
    end else begin
      cls_valid <= snap_valid;
      cls_white <= (snap_w >= WHITE_PIXELS);
      cls_color <= (snap_w >= WHITE_PIXELS) ? COLOR_NONE : frame_color;
    end
  end

  judge_state_t  state;
  color_t        cand, cand_nxt, dom_q;
  logic [SW-1:0] stable_cnt, white_run, stable_inc, white_inc, stable_nxt;

  always_comb begin
    stable_inc = (stable_cnt == SMAX) ? stable_cnt : stable_cnt + SW'(1);
    white_inc  = (white_run == SMAX) ? white_run : white_run + SW'(1);
    cand_nxt   = cand;
    stable_nxt = stable_cnt;
    if (cls_color == COLOR_NONE) begin
      stable_nxt = '0;
    end else if (cls_color == cand) begin
      stable_nxt = stable_inc;
    end else begin
      cand_nxt   = cls_color;
      stable_nxt = SW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_WHITE;
      cand         <= COLOR_NONE;
      dom_q        <= COLOR_NONE;
      stable_cnt   <= '0;
      white_run    <= '0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      if (cls_valid) begin
        case (state)
          S_WHITE: begin
            if (!cls_white) begin
              state     <= S_SEARCH;
              white_run <= '0;
              if (cls_color != COLOR_NONE) begin
                cand       <= cls_color;
                stable_cnt <= SW'(1);
              end else begin
                stable_cnt <= '0;
              end
            end
          end
          S_SEARCH: begin
            if (cls_white) begin
              white_run <= white_inc;
              if (white_inc == SMAX) begin
                state      <= S_WHITE;
                white_run  <= '0;
                stable_cnt <= '0;
              end
            end else begin
              white_run  <= '0;
              cand       <= cand_nxt;
              stable_cnt <= stable_nxt;
              if (stable_nxt == SMAX) begin
                state        <= S_LOCKED;
                dom_q        <= cand_nxt;
                result_valid <= 1'b1;
              end
            end
          end
          S_LOCKED: begin
            if (cls_white) begin
              white_run <= white_inc;
              if (white_inc == SMAX) begin
                state      <= S_WHITE;
                dom_q      <= COLOR_NONE;
                white_run  <= '0;
                stable_cnt <= '0;
              end
            end else begin
              white_run <= '0;
            end
          end
          default: state <= S_WHITE;
        endcase
      end
    end
  end

  assign dominant_color = dom_q;
  assign white_detected = (state == S_WHITE);
  assign state_dbg      = state;

`ifdef DICE_JUDGE_COUNT_OUT_EN
  assign dbg_cnt_r = snap_r;
  assign dbg_cnt_g = snap_g;
  assign dbg_cnt_b = snap_b;
  assign dbg_cnt_w = snap_w;
`endif

endmodule

// File: tb/tb_dice_color_judge.sv
// Table-driven bench for dice_color_judge plus hand-written sequences for
// mid-frame reset and back-to-back frame_end.
module tb_dice_color_judge;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        pixel_valid = 1'b0, in_roi = 1'b0, frame_end = 1'b0;
  logic        is_red = 1'b0, is_green = 1'b0, is_blue = 1'b0, is_white = 1'b0;
  logic [1:0]  dominant_color, state_dbg;
  logic        white_detected, result_valid;
`ifdef DICE_JUDGE_COUNT_OUT_EN
  logic [13:0] dbg_cnt_r, dbg_cnt_g, dbg_cnt_b, dbg_cnt_w;
`endif

  always #5 clk = ~clk;

  dice_color_judge dut (
    .clk           (clk),
    .reset         (reset),
    .pixel_valid   (pixel_valid),
    .in_roi        (in_roi),
    .is_red        (is_red),
    .is_green      (is_green),
    .is_blue       (is_blue),
    .is_white      (is_white),
    .frame_end     (frame_end),
    .dominant_color(dominant_color),
    .white_detected(white_detected),
    .state_dbg     (state_dbg),
    .result_valid  (result_valid)
`ifdef DICE_JUDGE_COUNT_OUT_EN
    ,
    .dbg_cnt_r     (dbg_cnt_r),
    .dbg_cnt_g     (dbg_cnt_g),
    .dbg_cnt_b     (dbg_cnt_b),
    .dbg_cnt_w     (dbg_cnt_w)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [3:0] exp_q[$];  // {result_valid, dominant_color, white_detected}

  typedef struct {
    bit         rst;
    int         r, g, b, w, xr;
    bit         rv;
    logic [1:0] col;
    bit         wh;
    int         snap_r;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic idle();
    pixel_valid = 1'b0; in_roi = 1'b0; frame_end = 1'b0;
    is_red = 1'b0; is_green = 1'b0; is_blue = 1'b0; is_white = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, " dominant"}, dominant_color, 0);
    check({tag, " white"}, white_detected, 1);
    check({tag, " rv"}, result_valid, 0);
    check({tag, " state"}, state_dbg, 0);
`ifdef DICE_JUDGE_COUNT_OUT_EN
    check({tag, " snap_r"}, dbg_cnt_r, 0);
    check({tag, " snap_w"}, dbg_cnt_w, 0);
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // xr stray red pixels (alternately outside the ROI / not valid) precede
  // the real pixels; frame_end rides on the last real pixel.
  task automatic send_frame(input int r, input int g, input int b, input int w,
                            input int xr, input bit idle_tail);
    int total;
    total = r + g + b + w;
    for (int i = 0; i < xr; i++) begin
      @(negedge clk);
      pixel_valid = (i % 2 == 0); in_roi = (i % 2 == 1);
      is_red = 1'b1; is_green = 1'b0; is_blue = 1'b0; is_white = 1'b0;
      frame_end = 1'b0;
    end
    for (int i = 0; i < total; i++) begin
      @(negedge clk);
      pixel_valid = 1'b1; in_roi = 1'b1;
      is_red   = (i < r);
      is_green = (i >= r && i < r + g);
      is_blue  = (i >= r + g && i < r + g + b);
      is_white = (i >= r + g + b);
      frame_end = (i == total - 1);
    end
    if (idle_tail) begin
      @(negedge clk);
      idle();
    end
  endtask

  // Called at the first negedge after the frame_end edge.
  task automatic finish_frame(input string tag, input int exp_snap_r);
    logic [3:0] e;
    e = exp_q.pop_front();
`ifdef DICE_JUDGE_COUNT_OUT_EN
    if (exp_snap_r >= 0) check({tag, " snap_r"}, dbg_cnt_r, exp_snap_r);
`endif
    check({tag, " rv@N+1"}, result_valid, 0);
    @(negedge clk);
    check({tag, " rv@N+2"}, result_valid, 0);
    @(negedge clk);
    check({tag, " rv@N+3"}, result_valid, e[3]);
    check({tag, " dominant"}, dominant_color, e[2:1]);
    check({tag, " white"}, white_detected, e[0]);
    @(negedge clk);
    check({tag, " rv@N+4"}, result_valid, 0);
  endtask

  task automatic add(input bit rst, input int r, input int g, input int b, input int w,
                     input int xr, input bit rv, input logic [1:0] col, input bit wh,
                     input int snap_r);
    vec_t v;
    v.rst = rst; v.r = r; v.g = g; v.b = b; v.w = w; v.xr = xr;
    v.rv = rv; v.col = col; v.wh = wh; v.snap_r = snap_r;
    vecs.push_back(v);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 16884 red pixels: a wrapping counter would read 500 (< MIN) and spoil the lock.
    add(1, 16884, 0, 0, 0, 0, 0, 2'd0, 0, 16383);
    add(0, 1000, 0, 0, 0, 0, 0, 2'd0, 0, 1000);
    add(0, 1000, 0, 0, 0, 0, 1, 2'd1, 0, -1);
    // R, R, G, G, G: green locks only on the fifth frame
    add(1, 800, 0, 0, 0, 0, 0, 2'd0, 0, 800);
    add(0, 800, 0, 0, 0, 0, 0, 2'd0, 0, -1);
    add(0, 0, 800, 0, 0, 0, 0, 2'd0, 0, 0);
    add(0, 0, 800, 0, 0, 0, 0, 2'd0, 0, -1);
    add(0, 0, 800, 0, 0, 0, 1, 2'd2, 0, -1);
    // blue lock, then W W B W W W at the exact white threshold
    add(1, 0, 0, 800, 0, 0, 0, 2'd0, 0, -1);
    add(0, 0, 0, 800, 0, 0, 0, 2'd0, 0, -1);
    add(0, 0, 0, 800, 0, 0, 1, 2'd3, 0, -1);
    add(0, 0, 0, 0, 10000, 0, 0, 2'd3, 0, -1);
    add(0, 0, 0, 0, 10000, 0, 0, 2'd3, 0, -1);
    add(0, 0, 0, 800, 0, 0, 0, 2'd3, 0, -1);
    add(0, 0, 0, 0, 10000, 0, 0, 2'd3, 0, -1);
    add(0, 0, 0, 0, 10000, 0, 0, 2'd3, 0, -1);
    add(0, 0, 0, 0, 10000, 0, 0, 2'd0, 1, -1);
    // R/G tie resolves to red
    add(1, 900, 900, 0, 0, 0, 0, 2'd0, 0, -1);
    add(0, 900, 900, 0, 0, 0, 0, 2'd0, 0, -1);
    add(0, 900, 900, 0, 0, 0, 1, 2'd1, 0, -1);
    // 799 red plus stray pixels that must not count: never locks
    add(1, 799, 0, 0, 0, 40, 0, 2'd0, 0, 799);
    add(0, 799, 0, 0, 0, 40, 0, 2'd0, 0, -1);
    add(0, 799, 0, 0, 0, 40, 0, 2'd0, 0, -1);

    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset("por");

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) begin
        do_reset();
        check_reset($sformatf("vec%0d reset", i));
      end
      exp_q.push_back({vecs[i].rv, vecs[i].col, vecs[i].wh});
      send_frame(vecs[i].r, vecs[i].g, vecs[i].b, vecs[i].w, vecs[i].xr, 1'b1);
      finish_frame($sformatf("vec%0d", i), vecs[i].snap_r);
    end

    // Reset mid-frame after 1000 red pixels; a leaked partial count would
    // out-vote the 900 green pixels of the first clean frame.
    do_reset();
    send_frame(0, 0, 0, 0, 0, 1'b0);
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      pixel_valid = 1'b1; in_roi = 1'b1; is_red = 1'b1;
    end
    @(negedge clk);
    idle();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset("midrst");
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back({k == 2, (k == 2) ? 2'd2 : 2'd0, 1'b0});
      send_frame(0, 900, 0, 0, 0, 1'b1);
      finish_frame($sformatf("midrst g%0d", k), (k == 0) ? 0 : -1);
    end

    // frame_end on consecutive cycles: red lock frame then a 1-pixel green frame
    do_reset();
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(4'b0000);
      send_frame(800, 0, 0, 0, 0, 1'b1);
      finish_frame($sformatf("b2b r%0d", k), 800);
    end
    send_frame(800, 0, 0, 0, 0, 1'b0);
    @(negedge clk);
    pixel_valid = 1'b1; in_roi = 1'b1; frame_end = 1'b1;
    is_red = 1'b0; is_green = 1'b1; is_blue = 1'b0; is_white = 1'b0;
    @(negedge clk);
    idle();
`ifdef DICE_JUDGE_COUNT_OUT_EN
    check("b2b snap2_r", dbg_cnt_r, 0);
    check("b2b snap2_g", dbg_cnt_g, 1);
`endif
    check("b2b rv@N+2", result_valid, 0);
    @(negedge clk);
    check("b2b rv@N+3", result_valid, 1);
    check("b2b dominant", dominant_color, 1);
    @(negedge clk);
    check("b2b rv@N+4", result_valid, 0);
    check("b2b dominant hold", dominant_color, 1);
    check("b2b state", state_dbg, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dice_color_judge.md
# dice_color_judge

Frame-level colour decision stage between the per-pixel colour classifier and the display overlay. It counts classified ROI pixels per frame and picks each frame's dominant colour. A debounce state machine then turns the per-frame results into a stable `dominant_color` plus a `white_detected` level (dice removed / idle). The overlay's indicator box and the game logic consume these outputs directly.

## Interface
Parameters:
- `CNT_W`, 14, width of the per-colour pixel counters (120x120 ROI = 14400 pixels max).
- `MIN_PIXELS`, 14'd800, minimum winning count for a frame to report RED/GREEN/BLUE.
- `WHITE_PIXELS`, 14'd10000, white count at or above which a frame is a white frame.
- `STABLE_FRAMES`, 3, consecutive agreeing frames required to lock a colour or to return to white.

Ports:
- `clk`  in  1  pixel-domain clock.
- `reset`  in  1  asynchronous, active-low reset.
- `pixel_valid`  in  1  one classified pixel present this cycle.
- `in_roi`  in  1  the current pixel lies inside the ROI.
- `is_red` / `is_green` / `is_blue` / `is_white`  in  1 each  classifier flags; at most one is high, and any combination is tolerated.
- `frame_end`  in  1  one-cycle pulse marking the last pixel of a frame.
- `dominant_color`  out  2  locked colour: 00 NONE, 01 RED, 10 GREEN, 11 BLUE.
- `white_detected`  out  1  level, high while in S_WHITE.
- `result_valid`  out  1  one-cycle pulse when a new colour locks.

## Operation
- Counting:
  - Four saturating counters (R, G, B, W) each increment when `pixel_valid && in_roi && flag`.
  - A counter at all-ones holds.
  - A pixel in the `frame_end` cycle counts toward the ending frame.
- Snapshot:
  - On `frame_end`, the final counts are copied into snapshot registers.
  - The live counters clear on the next cycle, so counting resumes there with no lost pixels.
- Frame classification, one cycle after the snapshot:
  - `white_frame` = W ≥ `WHITE_PIXELS`.
  - Otherwise the largest of R/G/B wins if it is ≥ `MIN_PIXELS`, else the frame is NONE.
  - Ties resolve R > G > B.
- FSM (S_WHITE, S_SEARCH, S_LOCKED) advances once per classified frame:
  - S_WHITE:
    - Any non-white frame → S_SEARCH, with `stable_cnt`=0 and `white_run`=0.
    - If that frame carries a colour, the candidate is loaded and `stable_cnt`=1.
  - S_SEARCH:
    - Colour frame equal to the candidate: `stable_cnt`++.
    - Different colour: the candidate is replaced and `stable_cnt`=1.
    - NONE frame: `stable_cnt`=0.
    - Any non-white frame clears `white_run`; a white frame increments it.
    - `stable_cnt` reaching `STABLE_FRAMES` → S_LOCKED, `dominant_color`=candidate, `result_valid` pulses.
    - `white_run` reaching `STABLE_FRAMES` → S_WHITE.
  - S_LOCKED:
    - `dominant_color` holds; colour changes are ignored.
    - White frames increment `white_run`; non-white frames clear it.
    - `white_run` reaching `STABLE_FRAMES` → S_WHITE, `dominant_color`=NONE.
- `white_detected` = (state == S_WHITE). `dominant_color` is NONE outside S_LOCKED.

## Timing
- Reset values: state S_WHITE, `dominant_color`=00, `white_detected`=1, `result_valid`=0, all counters, snapshots, `stable_cnt` and `white_run` zero.
- Latency: `frame_end` in cycle N → snapshot registered at N+1 → frame class at N+2 → outputs update at N+3.
- `result_valid` is high only in that N+3 cycle.
- Back-to-back `frame_end` pulses (even on consecutive cycles) are each processed in order; the pipeline has no stall.
- `stable_cnt` and `white_run` saturate at `STABLE_FRAMES`.
- Reset asserted mid-frame discards the partial counts and any in-flight classification.

## Configuration
- `DICE_JUDGE_COUNT_OUT_EN` defined:
  - Adds outputs `dbg_cnt_r`, `dbg_cnt_g`, `dbg_cnt_b`, `dbg_cnt_w` (`CNT_W` each, out), driven from the snapshot registers and reset to 0.
- Undefined: these ports and their drivers do not exist; decision behaviour is identical in both builds.

## Structure
- A shared package `color_pkg` holds:
  - the `color_t` enum (NONE/RED/GREEN/BLUE with the encodings above), also used by the overlay;
  - the `judge_state_t` enum.
- Sub-module `roi_color_counter` holds the four saturating counters, the snapshot registers and the clear-after-`frame_end` logic.
- The top level holds frame classification and the FSM.

## Test plan
- Reset, then 3 frames of 1000 red ROI pixels → `result_valid` pulses 3 cycles after the third `frame_end`; `dominant_color`=01, `white_detected`=0.
- Frames R, R, G, G, G (1000 px each) → lock to GREEN only after the fifth frame; there is no RED lock.
- Locked BLUE; then white, white, blue, white, white, white frames (10500 W px each) → S_WHITE only after the final white frame; `dominant_color`=00, `white_detected`=1.
- Frame with R=900, G=900, B=0 for 3 frames → ties resolve to RED (01); R=799 alone for 3 frames → never locks.
- 20000 red pixels in one frame → count saturates at 16383 with no wrap; debug build shows `dbg_cnt_r`=16383.
- Reset asserted mid-frame after 500 red pixels, then 3 clean 900-pixel green frames → GREEN locks; the partial red count is absent from the first snapshot.
